fir_frame_sequencer: RTL and testbench
======================================

Name: fir_frame_sequencer

Overview:
Controller that sequences the 8-bit-in / 16-bit-out FIR datapath on a frame basis. It accepts a frame of samples over a valid/ready stream and first purges the filter history with zeros. It then feeds the frame and flushes the tail with zeros. Filter outputs are returned as a framed valid/last stream with a done pulse. It sits between the sample source and the FIR filter, which advances only when the sequencer asserts fir_ce.

Parameters:
TAPS, 4, number of filter taps; sets the clear and flush lengths.
LATENCY, 1, cycles from a fir_ce=1 edge until the matching fir_y is valid; must be at least 1.
LEN_W, 8, width of frame_len.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle request to begin a frame; honoured only in IDLE
abort  in  1  synchronous abort; returns to IDLE from any state
frame_len  in  LEN_W  number of input samples in the frame; latched on an accepted start
s_valid  in  1  input sample valid
s_ready  out  1  sequencer can accept a sample this cycle
s_data  in  8  signed input sample
fir_x  out  8  signed sample presented to the filter
fir_ce  out  1  filter shift/accumulate enable
fir_y  in  16  signed filter output
m_valid  out  1  output sample valid; no backpressure
m_data  out  16  signed output sample
m_last  out  1  marks the final output of the frame
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the final output

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - s_ready, fir_ce, m_valid, m_last, busy and done are 0.
  - fir_x=0 and m_data=0.
  - Counters and the pipeline tag register are cleared.
- fir_x and fir_ce are combinational from state, s_valid and s_data. fir_x=0 whenever it is not carrying an accepted sample.
- States:
  - IDLE:
    - start=1 with frame_len!=0: latch frame_len and go to CLEAR.
    - start with frame_len=0: ignored; no outputs are produced.
  - CLEAR:
    - Exactly TAPS cycles with fir_ce=1 and fir_x=0. These outputs are not emitted.
    - Then go to RUN.
  - RUN:
    - s_ready=1.
    - On s_valid&&s_ready: fir_ce=1, fir_x=s_data, count++, and the cycle is tagged emit.
    - Cycles without s_valid: fir_ce=0; the filter holds its state.
    - When the frame_len-th sample is accepted, go to FLUSH. There are no idle cycles between.
  - FLUSH:
    - TAPS-1 cycles with fir_ce=1, fir_x=0 and s_ready=0. Each cycle is tagged emit.
    - The last FLUSH cycle is also tagged last.
    - Then go to DRAIN.
  - DRAIN:
    - fir_ce=0.
    - Wait until the tag pipeline is empty, then pulse done for 1 cycle and go to IDLE.
- Output pipeline:
  - The tag shift register is LATENCY stages deep and carries {emit, last} per fir_ce=1 cycle.
  - It advances every clock. A bubble is inserted when fir_ce=0.
  - When the tag at stage LATENCY has emit=1: register m_data<=fir_y, m_valid<=1, and m_last<=tag.last.
  - Otherwise m_valid<=0 and m_last<=0.
  - Accept-to-m_valid latency is LATENCY+1 cycles. With no input gaps, outputs are consecutive.
- Outputs per frame: exactly frame_len+TAPS-1 m_valid beats, with m_last on the final beat only.
- done is asserted the cycle after the m_last beat.
- start while busy=1: ignored, no side effects.
- abort=1:
  - Next state is IDLE; tags, counters and m_valid/m_last are cleared.
  - No done pulse and no further outputs.
  - abort has priority over start in the same cycle.
- Asynchronous reset mid-frame: immediate return to reset values; the in-progress frame is discarded.
- Count width is LEN_W; frame_len up to 2^LEN_W-1 is supported without wrap.

Test Plan:
- Reset values: hold reset=0 for 3 cycles with random inputs -> all outputs 0, busy=0.
- Basic frame: TAPS=4, LATENCY=1, moving-sum filter stub, frame_len=3, inputs 10,20,30 with no gaps -> m_data 10,30,60,60,50,30; m_last on the 6th beat; done 1 cycle after; busy falls with done.
- Input gaps: same frame with s_valid low for 2 cycles between each sample -> identical m_data sequence; fir_ce=0 on gap cycles; 6 beats total.
- History purge: run a frame of 40,40,40, then a second frame of 5 -> second frame outputs 5,5,5,5 with no residue from 40s.
- Abort and ignored starts: abort after the 2nd sample of a 5-sample frame -> m_valid=0 from the next cycle, no done, IDLE; start while busy and start with frame_len=0 -> ignored, no outputs.
- Async reset mid-FLUSH: deassert reset 3 cycles later, then start a frame_len=1 frame with input -7 -> outputs -7,-7,-7,-7, m_last on the 4th beat.

Source files
------------

// File: rtl/fir_frame_sequencer_if.sv
// Sample stream, FIR datapath handshake and framed result stream seen by the sequencer.
interface fir_frame_sequencer_if;
  logic               s_valid;
  logic               s_ready;
  logic signed [7:0]  s_data;
  logic signed [7:0]  fir_x;
  logic               fir_ce;
  logic signed [15:0] fir_y;
  logic               m_valid;
  logic signed [15:0] m_data;
  logic               m_last;

  modport master (
    input  s_valid, s_data, fir_y,
    output s_ready, fir_x, fir_ce, m_valid, m_data, m_last
  );

  modport slave (
    output s_valid, s_data, fir_y,
    input  s_ready, fir_x, fir_ce, m_valid, m_data, m_last
  );
endinterface

// File: rtl/fir_frame_sequencer.sv
// Frame sequencer for an FIR datapath: purge history, feed the frame, flush the tail,
// and return the filter outputs as a framed stream followed by a done pulse.
module fir_frame_sequencer #(
  parameter int TAPS    = 4,
  parameter int LATENCY = 1,
  parameter int LEN_W   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [LEN_W-1:0]      frame_len,
  fir_frame_sequencer_if.master io,
  output logic                  busy,
  output logic                  done
);
  localparam int PW = $clog2(TAPS + 1);
  localparam logic [PW-1:0] CLR_END = PW'(TAPS - 1);
  localparam logic [PW-1:0] FLS_END = PW'((TAPS > 1) ? TAPS - 2 : 0);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, FLUSH, DRAIN} state_t;
  typedef struct packed {
    logic emit;
    logic last;
  } tag_t;

  state_t                 state, state_nx;
  logic [LEN_W-1:0]       len_q, len_nx, cnt, cnt_nx;
  logic [PW-1:0]          pcnt, pcnt_nx;
  tag_t                   tag_in;
  tag_t [LATENCY:1]       tag_pipe;
  logic                   tags_busy, done_nx;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      len_q <= '0;
      cnt   <= '0;
      pcnt  <= '0;
    end else begin
      state <= state_nx;
      len_q <= len_nx;
      cnt   <= cnt_nx;
      pcnt  <= pcnt_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    len_nx     = len_q;
    cnt_nx     = cnt;
    pcnt_nx    = pcnt;
    tag_in     = '0;
    done_nx    = 1'b0;
    io.s_ready = 1'b0;
    io.fir_ce  = 1'b0;
    io.fir_x   = '0;
    case (state)
      IDLE: begin
        if (start && frame_len != '0) begin
          len_nx   = frame_len;
          cnt_nx   = '0;
          pcnt_nx  = '0;
          state_nx = CLEAR;
        end
      end
      CLEAR: begin
        io.fir_ce = 1'b1;
        pcnt_nx   = pcnt + PW'(1);
        if (pcnt == CLR_END) begin
          pcnt_nx  = '0;
          state_nx = RUN;
        end
      end
      RUN: begin
        io.s_ready = 1'b1;
        if (io.s_valid) begin
          io.fir_ce   = 1'b1;
          io.fir_x    = io.s_data;
          tag_in.emit = 1'b1;
          cnt_nx      = cnt + LEN_W'(1);
          // A single-tap filter has no tail, so the final sample itself closes the frame.
          if (cnt == len_q - LEN_W'(1)) begin
            tag_in.last = (TAPS == 1);
            state_nx    = (TAPS == 1) ? DRAIN : FLUSH;
          end
        end
      end
      FLUSH: begin
        io.fir_ce   = 1'b1;
        tag_in.emit = 1'b1;
        pcnt_nx     = pcnt + PW'(1);
        if (pcnt == FLS_END) begin
          tag_in.last = 1'b1;
          pcnt_nx     = '0;
          state_nx    = DRAIN;
        end
      end
      DRAIN: begin
        if (!tags_busy) begin
          done_nx  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (abort) begin
      state_nx = IDLE;
      cnt_nx   = '0;
      pcnt_nx  = '0;
      done_nx  = 1'b0;
    end
  end

  always_comb begin
    tags_busy = 1'b0;
    for (int i = 1; i <= LATENCY; i++) tags_busy = tags_busy | tag_pipe[i].emit;
  end

  // Tags travel alongside the filter latency so each emitted fir_y is captured exactly once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_pipe   <= '0;
      io.m_valid <= 1'b0;
      io.m_last  <= 1'b0;
      io.m_data  <= '0;
      done       <= 1'b0;
    end else if (abort) begin
      tag_pipe   <= '0;
      io.m_valid <= 1'b0;
      io.m_last  <= 1'b0;
      done       <= 1'b0;
    end else begin
      tag_pipe[1] <= tag_in;
      for (int i = 2; i <= LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
      io.m_valid <= tag_pipe[LATENCY].emit;
      io.m_last  <= tag_pipe[LATENCY].emit & tag_pipe[LATENCY].last;
      if (tag_pipe[LATENCY].emit) io.m_data <= io.fir_y;
      done <= done_nx;
    end
  end
endmodule

// File: tb/tb_fir_frame_sequencer.sv
// Randomized self-checking bench: moving-sum filter stub plus a convolution reference model.
module tb_fir_frame_sequencer;
  localparam int TAPS = 4, LATENCY = 1, LEN_W = 8;

  typedef int iq_t[$];
  typedef struct {
    logic signed [15:0] d;
    logic               l;
    int                 c;
  } beat_t;

  logic             clk = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0;
  logic [LEN_W-1:0] frame_len = '0;
  logic             busy, done;

  fir_frame_sequencer_if bus();

  fir_frame_sequencer #(.TAPS(TAPS), .LATENCY(LATENCY), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .frame_len(frame_len),
    .io(bus.master), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Filter stub: y = sum of the last TAPS accepted x values, valid one cycle after fir_ce.
  logic signed [7:0] hist [TAPS];
  always_ff @(posedge clk) begin
    if (bus.fir_ce) begin
      hist[0] <= bus.fir_x;
      for (int i = 1; i < TAPS; i++) hist[i] <= hist[i-1];
    end
  end
  always_comb begin
    bus.fir_y = '0;
    for (int i = 0; i < TAPS; i++) bus.fir_y = bus.fir_y + 16'(hist[i]);
  end

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  int    cyc = 0, done_cnt = 0, last_cyc = -10, first_acc = 0;
  beat_t obs[$];
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (bus.m_valid) begin
      obs.push_back('{d: bus.m_data, l: bus.m_last, c: cyc});
      if (bus.m_last) last_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      chk("done_after_last", cyc - last_cyc, 1);
      chk("busy_with_done", busy, 0);
    end
  end

  function automatic iq_t model(input iq_t xs);
    iq_t ys;
    for (int n = 0; n < xs.size() + TAPS - 1; n++) begin
      int s = 0;
      for (int k = 0; k < TAPS; k++)
        if (n - k >= 0 && n - k < xs.size()) s += xs[n-k];
      ys.push_back(s);
    end
    return ys;
  endfunction

  task automatic send_frame(input iq_t xs, input int flen, input int gap, input bit rnd_gap,
                            input bit busy_start);
    bit rdy;
    int guard, g;
    @(posedge clk); #1; start = 1'b1; frame_len = LEN_W'(flen);
    @(posedge clk); #1; start = 1'b0; frame_len = LEN_W'($urandom);
    if (busy_start) begin
      start = 1'b1; frame_len = LEN_W'(2);
      @(posedge clk); #1; start = 1'b0;
    end
    foreach (xs[i]) begin
      bus.s_valid = 1'b1; bus.s_data = 8'(xs[i]);
      guard = 0;
      do begin
        @(negedge clk); rdy = bus.s_ready;
        if (i == 0) first_acc = cyc;
        @(posedge clk); #1; guard++;
      end while (!rdy && guard < 100);
      if (!rdy) chk("ready_timeout", 0, 1);
      bus.s_valid = 1'b0; bus.s_data = 8'($urandom);
      if (i != xs.size() - 1) begin
        g = rnd_gap ? int'($urandom_range(0, 2)) : gap;
        repeat (g) begin
          @(negedge clk);
          chk("gap_ce", bus.fir_ce, 0);
          chk("gap_x", bus.fir_x, 0);
          @(posedge clk); #1;
        end
      end
    end
  endtask

  task automatic check_frame(input iq_t xs, input bit consec);
    iq_t ys = model(xs);
    chk("beats", obs.size(), ys.size());
    if (obs.size() > 0) chk("first_latency", obs[0].c - first_acc, LATENCY + 1);
    foreach (ys[i]) begin
      if (i < obs.size()) begin
        chk("m_data", 32'(obs[i].d), ys[i]);
        chk("m_last", obs[i].l, i == ys.size() - 1);
        if (consec && i > 0) chk("consec", obs[i].c - obs[i-1].c, 1);
      end
    end
  endtask

  task automatic run_frame(input iq_t xs, input int gap, input bit rnd_gap, input bit busy_start);
    int d0, t;
    obs.delete();
    d0 = done_cnt;
    send_frame(xs, xs.size(), gap, rnd_gap, busy_start);
    t = 0;
    while (done_cnt == d0 && t < 1000) begin @(negedge clk); t++; end
    chk("done_seen", done_cnt != d0, 1);
    repeat (3) @(negedge clk);
    chk("one_done", done_cnt - d0, 1);
    check_frame(xs, gap == 0 && !rnd_gap);
  endtask

  initial begin
    iq_t xs;
    int  d0;
    bit  bad;
    bus.s_valid = 1'b0; bus.s_data = '0;

    // Reset held with random inputs
    repeat (3) begin
      @(posedge clk); #1;
      start = 1'($urandom); abort = 1'($urandom); frame_len = LEN_W'($urandom);
      bus.s_valid = 1'($urandom); bus.s_data = 8'($urandom);
      @(negedge clk);
      chk("reset_outs", {bus.s_ready, bus.fir_ce, bus.fir_x, bus.m_valid, bus.m_data,
                         bus.m_last, busy, done}, 0);
    end
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0; bus.s_valid = 1'b0; reset = 1'b1;

    // Basic frame, gapped frame, history purge
    xs = '{10, 20, 30};  run_frame(xs, 0, 1'b0, 1'b0);
    xs = '{10, 20, 30};  run_frame(xs, 2, 1'b0, 1'b0);
    xs = '{40, 40, 40};  run_frame(xs, 0, 1'b0, 1'b0);
    xs = '{5};           run_frame(xs, 0, 1'b0, 1'b0);

    // Abort after the 2nd sample of a 5-sample frame, with a competing start
    obs.delete();
    d0 = done_cnt;
    xs = '{1, 2};
    send_frame(xs, 5, 0, 1'b0, 1'b0);
    abort = 1'b1; start = 1'b1; frame_len = LEN_W'(3);
    @(posedge clk); #1; abort = 1'b0; start = 1'b0;
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      bad = bad | bus.m_valid | done | busy;
    end
    chk("abort_quiet", bad, 0);
    chk("abort_no_done", done_cnt - d0, 0);

    // Start with frame_len=0 is ignored
    obs.delete();
    @(posedge clk); #1; start = 1'b1; frame_len = '0;
    @(posedge clk); #1; start = 1'b0;
    bad = 1'b0;
    repeat (10) begin @(negedge clk); bad = bad | busy; end
    chk("zero_len_busy", bad, 0);
    chk("zero_len_beats", obs.size(), 0);

    // Start while busy is ignored
    xs = '{3, -4, 5, 6}; run_frame(xs, 1, 1'b0, 1'b1);

    // Asynchronous reset in FLUSH, then a one-sample frame
    d0 = done_cnt;
    xs = '{7, 8, 9};
    send_frame(xs, 3, 0, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1 chk("async_rst", {busy, bus.m_valid, bus.m_last, bus.s_ready, bus.fir_ce, done}, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    chk("async_no_done", done_cnt - d0, 0);
    xs = '{-7};          run_frame(xs, 0, 1'b0, 1'b0);

    // Random frames with random gaps
    repeat (6) begin
      xs = {};
      repeat ($urandom_range(1, 12)) xs.push_back(int'($signed(8'($urandom))));
      run_frame(xs, 0, 1'b1, 1'b0);
    end

    // Longest frame: the sample counter must not wrap
    xs = {};
    repeat (255) xs.push_back(int'($signed(8'($urandom))));
    run_frame(xs, 0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
